// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port bundle shared by the requesters and the arbiter.
// master: requester/clear side (drives requests), slave: arbiter side.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_dr;
    logic [NREQ*DW-1:0] req_data;
    logic               clr_start;
    logic [NREQ-1:0]    gnt;
    logic               write;
    logic [AW-1:0]      dr;
    logic [DW-1:0]      wrData;
    logic               busy;

    modport master (
        output req, req_dr, req_data, clr_start,
        input  gnt, write, dr, wrData, busy
    );

    modport slave (
        input  req, req_dr, req_data, clr_start,
        output gnt, write, dr, wrData, busy
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Optional feature macro REGARB_CLEAR_EN: adds a CLEAR state that writes zero
// to all 32 registers on a clr_start pulse. Without it the FSM stays in IDLE,
// clr_start is ignored and busy is constant 0.
module regfile_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic            write_q;
    logic [AW-1:0]   dr_q;
    logic [DW-1:0]   wdata_q;
    logic            busy_q;
`ifdef REGARB_CLEAR_EN
    logic [4:0]      cnt_q;   // next register address to clear
`else
    logic            unused_clr;
    assign unused_clr = bus.clr_start;
`endif

    logic [NREQ-1:0] req_m;
    logic            win_vld;
    logic [PW-1:0]   win_idx;

    logic [AW-1:0]   dr_arr   [NREQ];
    logic [DW-1:0]   data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign dr_arr[g]   = bus.req_dr[g*AW +: AW];
        assign data_arr[g] = bus.req_data[g*DW +: DW];
    end

    // Index k positions after p, modulo NREQ.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
        return PW'((int'(p) + k) % NREQ);
    endfunction

    // Winner search from ptr+1 upward; the requester holding the current grant
    // is masked so a late req drop cannot cause a second grant.
    always_comb begin
        req_m   = bus.req & ~gnt_q;
        win_vld = 1'b0;
        win_idx = ptr_q;
        // Walk farthest-to-nearest so the nearest hit after ptr overwrites.
        for (int k = NREQ; k >= 1; k--) begin
            if (req_m[rr_idx(ptr_q, k)]) begin
                win_vld = 1'b1;
                win_idx = rr_idx(ptr_q, k);
            end
        end
    end

    // FSM with registered write-port outputs; dr/wrData hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            gnt_q   <= '0;
            write_q <= 1'b0;
            dr_q    <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
`ifdef REGARB_CLEAR_EN
            cnt_q   <= '0;
`endif
        end else begin
            gnt_q   <= '0;
            write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
`ifdef REGARB_CLEAR_EN
                    // Clear beats any same-cycle request; register 0 is
                    // written on the entry edge so there is no dead cycle.
                    if (bus.clr_start) begin
                        state_q <= CLEAR;
                        write_q <= 1'b1;
                        dr_q    <= '0;
                        wdata_q <= '0;
                        busy_q  <= 1'b1;
                        cnt_q   <= 5'd1;
                    end else
`endif
                    if (win_vld) begin
                        gnt_q[win_idx] <= 1'b1;
                        write_q        <= 1'b1;
                        dr_q           <= dr_arr[win_idx];
                        wdata_q        <= data_arr[win_idx];
                        ptr_q          <= win_idx;
                    end
                end
`ifdef REGARB_CLEAR_EN
                CLEAR: begin
                    // clr_start is not looked at here: no restart or extension.
                    write_q <= 1'b1;
                    dr_q    <= AW'(cnt_q);
                    wdata_q <= '0;
                    busy_q  <= 1'b1;
                    cnt_q   <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.write  = write_q;
    assign bus.dr     = dr_q;
    assign bus.wrData = wdata_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (NREQ=4, AW=5, DW=32). Expected
// outputs are queued when a step's inputs are driven and compared one edge later.
module tb_regfile_wr_arbiter;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    typedef struct packed {
        logic [3:0]  gnt;
        logic        write;
        logic [4:0]  dr;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    regfile_wr_arbiter_if #(.NREQ(4), .AW(5), .DW(32)) bus ();

    regfile_wr_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        exp_t o;
        exp_t e;
        o = '{gnt: bus.gnt, write: bus.write, dr: bus.dr, data: bus.wrData, busy: bus.busy};
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, o);
        end else begin
            e = sb.pop_front();
            assert (o === e) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", tag, o, e);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected registered outputs,
    // then compare just after the next rising edge.
    task automatic step(input logic [3:0] r, input logic c,
                        input logic [3:0] eg, input logic ew, input logic [4:0] edr,
                        input logic [31:0] ed, input logic eb, input string tag);
        bus.req       = r;
        bus.clr_start = c;
        sb.push_back('{gnt: eg, write: ew, dr: edr, data: ed, busy: eb});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.clr_start = 1'b0;
        bus.req_dr    = {5'd15, 5'd11, 5'd7, 5'd3};
        bus.req_data  = {32'd330, 32'd230, 32'd130, 32'd30};

        // Reset holds everything at zero even with requests pending.
        @(posedge clk);
        #1;
        bus.req = 4'b1111;
        @(posedge clk);
        #1;
        sb.push_back('0);
        check("reset_state");

        // First edge after release grants; ptr reset makes requester 0 first.
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b0, 4'(1 << (k % 4)), 1'b1, 5'(3 + 4 * (k % 4)),
                 32'(30 + 100 * (k % 4)), 1'b0, $sformatf("rr_all_%0d", k));
        end
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 5'd15, 32'd330, 1'b0, "idle_hold");

        // Single requester, held one cycle past grant: masked, then dropped.
        step(4'b0001, 1'b0, 4'b0001, 1'b1, 5'd3, 32'd30, 1'b0, "req0_grant");
        step(4'b0001, 1'b0, 4'b0000, 1'b0, 5'd3, 32'd30, 1'b0, "req0_masked");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 5'd3, 32'd30, 1'b0, "req0_dropped");

        // Move ptr to 1, then 1001 must go 3 before 0.
        step(4'b0010, 1'b0, 4'b0010, 1'b1, 5'd7, 32'd130, 1'b0, "req1_grant");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 5'd7, 32'd130, 1'b0, "ptr1_idle");
        step(4'b1001, 1'b0, 4'b1000, 1'b1, 5'd15, 32'd330, 1'b0, "ptr1_gnt3");
        step(4'b1001, 1'b0, 4'b0001, 1'b1, 5'd3, 32'd30, 1'b0, "ptr1_gnt0");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 5'd3, 32'd30, 1'b0, "ptr1_done");

`ifdef REGARB_CLEAR_EN
        // Clear wins over a same-cycle request; a mid-sequence clr_start is ignored.
        step(4'b0010, 1'b1, 4'b0000, 1'b1, 5'd0, 32'd0, 1'b1, "clr_0");
        for (int k = 1; k < 32; k++) begin
            step(4'b0010, (k == 5), 4'b0000, 1'b1, 5'(k), 32'd0, 1'b1,
                 $sformatf("clr_%0d", k));
        end
        step(4'b0010, 1'b0, 4'b0010, 1'b1, 5'd7, 32'd130, 1'b0, "clr_then_gnt1");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 5'd7, 32'd130, 1'b0, "clr_after_idle");

        // Abort a clear at count 10 with reset.
        step(4'b0000, 1'b1, 4'b0000, 1'b1, 5'd0, 32'd0, 1'b1, "clr2_0");
        for (int k = 1; k <= 10; k++) begin
            step(4'b0000, 1'b0, 4'b0000, 1'b1, 5'(k), 32'd0, 1'b1,
                 $sformatf("clr2_%0d", k));
        end
`else
        // clr_start has no effect in this build.
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 1'b1, 4'b0000, 1'b0, 5'd3, 32'd30, 1'b0,
                 $sformatf("noclr_%0d", k));
        end
        step(4'b0100, 1'b1, 4'b0100, 1'b1, 5'd11, 32'd230, 1'b0, "noclr_gnt2");
`endif

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        bus.clr_start = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        sb.push_back('0);
        check("async_reset");
        @(posedge clk);
        #1;
        sb.push_back('0);
        check("reset_held");

        // After release: no resumed clear, ptr back to NREQ-1.
        reset_n = 1'b1;
        step(4'b1001, 1'b0, 4'b0001, 1'b1, 5'd3, 32'd30, 1'b0, "post_rst_gnt0");
        step(4'b1001, 1'b0, 4'b1000, 1'b1, 5'd15, 32'd330, 1'b0, "post_rst_gnt3");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 5'd15, 32'd330, 1'b0, "post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters sharing the register-file write port (2..8).
REQ-002 Parameter AW, default 5: destination register address width (32 registers).
REQ-003 Parameter DW, default 32: write data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester write request, level, held until granted.
REQ-007 req_dr  input  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW].
REQ-008 req_data  input  NREQ*DW  packed write data; requester i at [i*DW +: DW].
REQ-009 clr_start  input  1  single-cycle pulse requesting a clear of all 32 registers.
REQ-010 gnt  output  NREQ  one-hot grant, one-cycle pulse, registered.
REQ-011 write  output  1  register-file write enable, registered.
REQ-012 dr  output  AW  register-file destination address, registered.
REQ-013 wrData  output  DW  register-file write data, registered.
REQ-014 busy  output  1  high while the clear sequence owns the write port.

Function
REQ-015 The block SHALL be an FSM with states IDLE and CLEAR; IDLE performs round-robin arbitration.
REQ-016 In IDLE, the winner at edge N SHALL be the first requester with req=1, searched from ptr+1 upward modulo NREQ, where ptr is the last granted index.
REQ-017 On the edge after selection, gnt[w]=1, write=1, dr=req_dr[w], wrData=req_data[w] for exactly one cycle; latency req->write is one cycle.
REQ-018 ptr SHALL update to w on every grant and hold otherwise.
REQ-019 While gnt[i]=1, req[i] SHALL be masked from arbitration, so a requester that drops req on the edge after gnt is never double-granted.
REQ-020 A different requester SHALL be grantable in the cycle immediately following a grant (back-to-back writes, one per cycle).
REQ-021 With no req bits set (after masking), gnt=0 and write=0; dr and wrData hold their previous values.
REQ-022 Sustained requests from all NREQ requesters SHALL each be granted exactly once per NREQ grants.
REQ-023 clr_start in IDLE SHALL move to CLEAR; if req is also active that cycle, clear wins and no grant is issued.
REQ-024 In CLEAR, a 5-bit counter starting at 0 SHALL drive write=1, dr=counter, wrData=0, gnt=0, busy=1 each cycle, incrementing by 1.
REQ-025 After the cycle writing dr=31, the FSM SHALL return to IDLE (32 write cycles total); ptr is unchanged by CLEAR.
REQ-026 clr_start while in CLEAR SHALL be ignored (no restart, no extension).
REQ-027 Requests pending during CLEAR SHALL be held off and arbitrated normally from the first IDLE cycle.

Reset
REQ-028 reset_n=0 SHALL immediately force gnt=0, write=0, dr=0, wrData=0, busy=0, state=IDLE, counter=0, ptr=NREQ-1 (requester 0 highest priority first).
REQ-029 Reset asserted during CLEAR SHALL abort the sequence; no resume after release.
REQ-030 The first grant SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-031 Macro REGARB_CLEAR_EN defined: CLEAR state, counter and clr_start handling SHALL be present as specified above.
REQ-032 Macro REGARB_CLEAR_EN undefined: clr_start SHALL be ignored, busy tied 0, FSM permanently IDLE; arbitration behaviour identical.

Verification
REQ-033 Reset release, req=4'b0001, req_dr[0]=3, req_data[0]=30 -> next cycle gnt=0001, write=1, dr=3, wrData=30; req dropped -> write=0 next cycle.
REQ-034 req=4'b1111 held (each requester drops req the cycle after its gnt, reasserts 1 cycle later) -> grant order 0,1,2,3,0,... with write=1 every cycle.
REQ-035 ptr=1, req=4'b1001 -> gnt=1000 first, then 0001.
REQ-036 clr_start pulse with req=4'b0010 same cycle -> 32 cycles write=1, dr=0..31, wrData=0, busy=1, gnt=0; then gnt=0010 on first IDLE edge.
REQ-037 reset_n pulsed low at clear count 10 -> all outputs 0 immediately; after release busy=0 and a new req is granted normally.
REQ-038 Build without REGARB_CLEAR_EN, pulse clr_start with req=0 -> busy=0, write=0 throughout.
